// File: rtl/comparator_1_bit_df.sv
// comparator_1_bit_df
// Registered 1-bit magnitude comparator with per-result event counters.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   a, b       compare operands
//   in_valid   sample strobe; a/b accepted on a rising edge with rst_n=1
//   e, g, l    registered result: a==b, a>b, a<b (one-hot once a sample is seen)
//   out_valid  one-cycle pulse per accepted sample
//   changed    pulse with out_valid when the new result differs from the last
//   eq_cnt     saturating count of accepted samples with a==b
//   gt_cnt     saturating count of accepted samples with a>b
//   lt_cnt     saturating count of accepted samples with a<b
module comparator_1_bit_df #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    output logic             e,
    output logic             g,
    output logic             l,
    output logic             out_valid,
    output logic             changed,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       res_e;
    logic       res_g;
    logic       res_l;
    logic [2:0] res_egl;

    always_comb begin
        res_e   = ~(a ^ b);
        res_g   = a & ~b;
        res_l   = ~a & b;
        res_egl = {res_e, res_g, res_l};
    end

    // The registered {e,g,l} doubles as the "previous result" history. It is
    // 000 after reset and one-hot afterwards, so the first accepted sample
    // always reports changed=1 without a separate first-sample flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e         <= 1'b0;
            g         <= 1'b0;
            l         <= 1'b0;
            out_valid <= 1'b0;
            changed   <= 1'b0;
            eq_cnt    <= '0;
            gt_cnt    <= '0;
            lt_cnt    <= '0;
        end else if (in_valid) begin
            e         <= res_e;
            g         <= res_g;
            l         <= res_l;
            out_valid <= 1'b1;
            changed   <= (res_egl != {e, g, l});
            if (res_e && (eq_cnt != CNT_MAX)) eq_cnt <= eq_cnt + 1'b1;
            if (res_g && (gt_cnt != CNT_MAX)) gt_cnt <= gt_cnt + 1'b1;
            if (res_l && (lt_cnt != CNT_MAX)) lt_cnt <= lt_cnt + 1'b1;
        end else begin
            out_valid <= 1'b0;
            changed   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_comparator_1_bit_df.sv
module tb_comparator_1_bit_df;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic             in_valid = 1'b0;
    logic             e, g, l, out_valid, changed;
    logic [CNT_W-1:0] eq_cnt, gt_cnt, lt_cnt;

    comparator_1_bit_df #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .e         (e),
        .g         (g),
        .l         (l),
        .out_valid (out_valid),
        .changed   (changed),
        .eq_cnt    (eq_cnt),
        .gt_cnt    (gt_cnt),
        .lt_cnt    (lt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       egl;
        logic             chg;
        logic [CNT_W-1:0] eq;
        logic [CNT_W-1:0] gt;
        logic [CNT_W-1:0] lt;
    } exp_t;

    exp_t             sb_q[$];
    int               checks = 0;
    int               errors = 0;
    bit               run = 1'b0;

    // reference model state (what the registers must hold after the next edge)
    logic [2:0]       m_egl = 3'b000;
    logic [CNT_W-1:0] m_eq = '0, m_gt = '0, m_lt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    // drive one cycle at the falling edge; update model and scoreboard
    task automatic step(input logic ai, input logic bi, input logic vi, input logic ri);
        exp_t       x;
        logic [2:0] res;
        @(negedge clk);
        a        = ai;
        b        = bi;
        in_valid = vi;
        rst_n    = ri;
        if (!ri) begin
            m_egl = 3'b000;
            m_eq  = '0;
            m_gt  = '0;
            m_lt  = '0;
        end else if (vi) begin
            res = (ai == bi) ? 3'b100 : (ai ? 3'b010 : 3'b001);
            x.chg = (res != m_egl);
            m_egl = res;
            if (res[2]) m_eq = sat_inc(m_eq);
            if (res[1]) m_gt = sat_inc(m_gt);
            if (res[0]) m_lt = sat_inc(m_lt);
            x.egl = res;
            x.eq  = m_eq;
            x.gt  = m_gt;
            x.lt  = m_lt;
            sb_q.push_back(x);
        end
    endtask

    // monitor: sample 1 time unit after every rising edge
    always @(posedge clk) begin
        exp_t x;
        if (run) begin
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("out_valid", {31'b0, out_valid}, 32'd1);
                check("egl", {29'b0, e, g, l}, {29'b0, x.egl});
                check("changed", {31'b0, changed}, {31'b0, x.chg});
                check("eq_cnt", {24'b0, eq_cnt}, {24'b0, x.eq});
                check("gt_cnt", {24'b0, gt_cnt}, {24'b0, x.gt});
                check("lt_cnt", {24'b0, lt_cnt}, {24'b0, x.lt});
            end else begin
                check("idle_out_valid", {31'b0, out_valid}, 32'd0);
                check("idle_changed", {31'b0, changed}, 32'd0);
                check("hold_egl", {29'b0, e, g, l}, {29'b0, m_egl});
                check("hold_cnt", {8'b0, eq_cnt, gt_cnt, lt_cnt}, {8'b0, m_eq, m_gt, m_lt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        run = 1'b1;
        // reset, including a valid sample during reset that must be discarded
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        check("rst_cnt", {8'b0, eq_cnt, gt_cnt, lt_cnt}, 32'd0);

        // truth table sweep
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        step(1, 0, 1, 1);
        step(1, 1, 1, 1);
        step(0, 0, 0, 1);
        check("sweep_counts", {8'b0, eq_cnt, gt_cnt, lt_cnt}, {8'b0, 8'd2, 8'd1, 8'd1});

        // accept (1,0) then idle while toggling inputs
        step(1, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(i[0], ~i[0], 0, 1);
        check("idle_g_held", {29'b0, e, g, l}, 32'b010);

        // (1,1) twice: changed 1 then 0
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        step(0, 0, 0, 1);

        // saturation from a clean reset
        step(0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 1, 1, 1);
        step(0, 0, 0, 1);
        check("lt_sat", {24'b0, lt_cnt}, 32'd255);
        check("sat_others", {16'b0, eq_cnt, gt_cnt}, 32'd0);

        // one more (0,1) at saturation, then other counters still advance
        step(0, 1, 1, 1);
        step(1, 0, 1, 1);
        step(1, 1, 1, 1);

        // mid-stream reset with in_valid high
        step(1, 0, 1, 1);
        step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);

        // random stream with occasional idles
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), 1'b1);
        step(1, 0, 1, 1);
        step(0, 0, 0, 1);

        // reset asserted without a clock edge: outputs must not move yet
        @(negedge clk);
        run      = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #2;
        check("sync_rst_egl", {29'b0, e, g, l}, 32'b010);
        check("sync_rst_gt_nonzero", {31'b0, (gt_cnt != 0)}, 32'd1);
        @(posedge clk);
        #1;
        check("sync_rst_applied", {5'b0, e, g, l, out_valid, changed, eq_cnt, gt_cnt, lt_cnt}, 32'd0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
